fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage for the MIPS core. It sits directly upstream of the controller and datapath.
- Owns the PC and issues word reads to instruction memory over a ready-handshake interface.
- Holds the fetched word in an instruction register and presents op/funct to the controller.
- Computes the next PC from the controller's pcsrc/jump when the downstream stage accepts the instruction.
- Counts retired instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0 (elaboration-time assertion).
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-high reset.
imem_req  output  1  read request, valid only in FETCH.
imem_addr  output  32  word-aligned read address; equals pc.
imem_rdata  input  32  read data, sampled when imem_req & imem_ready.
imem_ready  input  1  memory completes the read this cycle; 0 or more wait cycles.
instr_valid  output  1  instr holds a fetched instruction that has not yet been accepted.
instr_accept  input  1  downstream executes instr this cycle; pcsrc and jump are sampled now.
pcsrc  input  1  take branch (branch & zero from controller).
jump  input  1  take jump.
instr  output  32  instruction register.
op  output  6  instr[31:26].
funct  output  6  instr[5:0].
pc  output  32  address of instr.
pc_plus4  output  32  pc + 4.
retired  output  CNT_W  count of accepted instructions.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=BOOT, pc=RESET_PC, instr=32'h0, instr_valid=0, retired=0.
  - imem_req=0 while in BOOT.
- State machine, states BOOT, FETCH, HOLD:
  - BOOT -> FETCH unconditionally, one cycle after reset deasserts.
  - FETCH: imem_req=1, imem_addr=pc. If imem_ready, instr<=imem_rdata and go to HOLD. Otherwise stay in FETCH with req held and addr stable.
  - HOLD: instr_valid=1; instr and pc are stable. If instr_accept, pc<=next_pc, retired<=retired+1, go to FETCH. Otherwise stay in HOLD.
- next_pc selection, evaluated in the accept cycle:
  - jump=1 (has priority over pcsrc): {pc_plus4[31:28], instr[25:0], 2'b00}.
  - pcsrc=1: pc_plus4 + (signimm << 2), where signimm = sign-extended instr[15:0].
  - otherwise: pc_plus4.
  - All arithmetic is 32-bit modulo; PC wraps 32'hFFFF_FFFC -> 32'h0 with no error.
- Latency and throughput:
  - With zero-wait memory and immediate accept: 2 cycles per instruction.
  - Latency from imem_ready to instr_valid is 1 cycle.
- Ignored inputs:
  - imem_ready outside FETCH is ignored; memory must not complete an un-requested read.
  - instr_accept while instr_valid=0 is ignored: no PC change, no count.
  - pcsrc and jump are ignored except in an accept cycle.
- Output derivation:
  - instr_valid, imem_req: decoded from the state register (registered, glitch-free).
  - op, funct: combinational slices of instr.
  - pc_plus4: combinational from pc.
- retired wraps to 0 on overflow.
- Reset in the middle of FETCH abandons the read; the memory shares the same reset, so no stale response is possible.
- imem_addr[1:0] is always 2'b00 by construction.

Decomposition:
- mips_pkg:
  - typedef enum logic [1:0] fetch_state_t {BOOT, FETCH, HOLD}.
  - Opcode localparams OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100, OP_ADDI=6'b001000, OP_J=6'b000010, shared with the controller.
- One sub-module, nextpc: purely combinational. Inputs pc_plus4, instr, pcsrc, jump; output next_pc. It is reused later by the pipelined core.

Test Plan:
1. Reset release, zero-wait memory, RESET_PC=0, rdata=32'h2008_0005 (addi), accept in every HOLD cycle -> first imem_req on cycle 2 at addr 0; instr_valid next cycle; pc sequence 0,4,8; retired=3 after three accepts.
2. imem_ready delayed 3 cycles -> imem_req and imem_addr held stable for 4 cycles; instr_valid=0 throughout; instr captured only on the ready cycle.
3. pc=32'h10, instr=32'h1000_FFFE (beq, offset -2), pcsrc=1 at accept -> pc=32'h0C. Repeat with pcsrc=0 -> pc=32'h14.
4. pc=32'h4000_0020, instr=32'h0800_0040 (j), jump=1 and pcsrc=1 together -> pc=32'h4000_0100 (jump wins).
5. instr_accept held low for 5 HOLD cycles, plus a stray accept and a stray imem_ready -> instr and pc unchanged; retired unchanged; no extra fetch.
6. Assert reset during FETCH with pc=32'h8 -> immediately pc=RESET_PC, instr_valid=0, imem_req=0; fetch resumes from RESET_PC after one BOOT cycle. Also pc=32'hFFFF_FFFC, no branch -> wraps to 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS core.
//   fetch_state_t - fetch stage state encoding (BOOT, FETCH, HOLD).
//   OP_*          - primary opcode values, shared with the controller.
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the instruction-memory read handshake and the
// instruction hand-off to the controller/datapath.
//   master - the fetch unit: drives imem_req/imem_addr and the instruction
//            outputs; receives imem_rdata/imem_ready, instr_accept,
//            pcsrc and jump.
//   slave  - the environment (memory + downstream stage), opposite directions.
// CNT_W sets the width of the retired-instruction counter.
interface fetch_unit_if #(
  parameter int unsigned CNT_W = 32
);
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_rdata;
  logic             imem_ready;
  logic             instr_valid;
  logic             instr_accept;
  logic             pcsrc;
  logic             jump;
  logic [31:0]      instr;
  logic [5:0]       op;
  logic [5:0]       funct;
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic [CNT_W-1:0] retired;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, op, funct, pc, pc_plus4,
           retired,
    input  imem_rdata, imem_ready, instr_accept, pcsrc, jump
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, op, funct, pc, pc_plus4,
           retired,
    output imem_rdata, imem_ready, instr_accept, pcsrc, jump
  );

endinterface

// File: rtl/fetch_unit_nextpc.sv
// nextpc: purely combinational next-PC selection.
//   pc_plus4 - address of the following sequential instruction.
//   instr    - current instruction (immediate / jump index fields used).
//   pcsrc    - take the branch (pc_plus4 + signimm*4).
//   jump     - take the jump; has priority over pcsrc.
//   next_pc  - selected next PC (32-bit modulo arithmetic).
module nextpc (
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        pcsrc,
  input  logic        jump,
  output logic [31:0] next_pc
);

  logic [31:0] branch_offset;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        unused_opcode;

  // Sign-extended 16-bit immediate, already scaled by 4.
  assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign branch_target = pc_plus4 + branch_offset;
  assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign unused_opcode = ^instr[31:26];

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (pcsrc) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
//   clk   - rising-edge clock.
//   reset - asynchronous active-high reset.
//   bus   - fetch_unit_if.master: instruction memory read handshake
//           (imem_req/imem_addr/imem_rdata/imem_ready), instruction hand-off
//           (instr_valid/instr_accept/instr/op/funct/pc/pc_plus4), branch
//           controls (pcsrc/jump) and the retired-instruction count.
// Owns the PC, fetches one word per instruction into an instruction
// register, holds it until downstream accepts, then advances the PC.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_check
    $error("fetch_unit: RESET_PC must be word aligned");
  end

  fetch_state_t     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [31:0]      pc_plus4;
  logic [31:0]      next_pc;
  logic             imem_req;
  logic             instr_valid;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   if (bus.imem_ready)   state_d = HOLD;
      HOLD:    if (bus.instr_accept) state_d = FETCH;
      default: state_d = BOOT;
    endcase
  end

  // Outputs decoded from the state register only, so they never glitch on
  // handshake inputs.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state_q)
      FETCH:   imem_req    = 1'b1;
      HOLD:    instr_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture on a completed read, advance on accept. Handshake
  // inputs outside their own state are ignored by qualifying on state_q.
  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    if (state_q == FETCH && bus.imem_ready) begin
      instr_d = bus.imem_rdata;
    end
    if (state_q == HOLD && bus.instr_accept) begin
      pc_d      = next_pc;
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  assign pc_plus4 = pc_q + 32'd4;

  nextpc u_nextpc (
    .pc_plus4 (pc_plus4),
    .instr    (instr_q),
    .pcsrc    (bus.pcsrc),
    .jump     (bus.jump),
    .next_pc  (next_pc)
  );

  // Every PC source is a multiple of 4, so imem_addr[1:0] stays 2'b00.
  assign bus.imem_req    = imem_req;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = instr_valid;
  assign bus.instr       = instr_q;
  assign bus.op          = instr_q[31:26];
  assign bus.funct       = instr_q[5:0];
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.retired     = retired_q;

endmodule
